he_pipe_enc: RTL and testbench

Streaming Hamming(k+m, k) single-error-correcting encoder, the transmit-side counterpart of the hd_top decoder. Accepts k-bit data words on a valid/ready input, inserts m even-parity bits at power-of-two codeword positions, and presents (k+m)-bit codewords on a valid/ready output through a two-stage pipeline with full backpressure. Its cout/cvld output connects directly to the decoder's cin/cvld input; crdy is tied high in that configuration.

---
 rtl/he_pkg.sv | 59 +++++
 rtl/he_pipe_stage.sv | 28 ++
 rtl/he_pipe_enc.sv | 61 ++++++
 tb/tb_he_pipe_enc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/he_pkg.sv
// Shared Hamming helpers for the he_pipe_enc encoder and its decoder counterpart.
// Functions work on max-width vectors; callers cast to their own k/m/CW widths.
package he_pkg;

   localparam int unsigned HE_K_MAX  = 26;
   localparam int unsigned HE_M_MAX  = 5;
   localparam int unsigned HE_CW_MAX = HE_K_MAX + HE_M_MAX;

   // Smallest m with 2^m >= k + m + 1.
   function automatic int unsigned he_m(input int unsigned k);
      int unsigned m;
      m = 1;
      for (int unsigned i = 0; i <= HE_M_MAX; i++)
         if ((32'd1 << m) < k + m + 1) m = m + 1;
      return m;
   endfunction

   function automatic logic he_is_pow2(input int unsigned pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Data bits go to non-power-of-two positions in ascending order; parity slots stay 0.
   function automatic logic [HE_CW_MAX-1:0] he_scatter(input logic [HE_K_MAX-1:0] d,
                                                        input int unsigned k);
      logic [HE_CW_MAX-1:0] v;
      int unsigned di;
      v  = '0;
      di = 0;
      for (int unsigned p = 1; p <= HE_CW_MAX; p++)
         if (!he_is_pow2(p) && di < k) begin
            v[5'(p - 1)] = d[5'(di)];
            di = di + 1;
         end
      return v;
   endfunction

   // p_i = XOR of every bit whose 1-based position has bit i set.
   function automatic logic [HE_M_MAX-1:0] he_parity(input logic [HE_CW_MAX-1:0] v,
                                                      input int unsigned m);
      logic [HE_M_MAX-1:0] par;
      par = '0;
      for (int unsigned i = 0; i < HE_M_MAX; i++)
         for (int unsigned p = 1; p <= HE_CW_MAX; p++)
            if (i < m && ((p >> i) & 32'd1) != 0)
               par[3'(i)] = par[3'(i)] ^ v[5'(p - 1)];
      return par;
   endfunction

   function automatic logic [HE_CW_MAX-1:0] he_place(input logic [HE_CW_MAX-1:0] v,
                                                      input logic [HE_M_MAX-1:0] par,
                                                      input int unsigned m);
      logic [HE_CW_MAX-1:0] r;
      r = v;
      for (int unsigned i = 0; i < HE_M_MAX; i++)
         if (i < m) r[5'((32'd1 << i) - 1)] = par[3'(i)];
      return r;
   endfunction

endpackage

// File: rtl/he_pipe_stage.sv
// Generic valid/ready register slice; accepts whenever empty or draining.
module he_pipe_stage #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_d,
   input  logic         in_vld,
   output logic         in_rdy_c,
   output logic [W-1:0] out_d,
   output logic         out_vld,
   input  logic         out_rdy
);

   assign in_rdy_c = !out_vld || out_rdy;

   // Payload only loads on a real transfer, so a stalled word never changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vld <= 1'b0;
         out_d   <= '0;
      end else if (in_rdy_c) begin
         out_vld <= in_vld;
         if (in_vld) out_d <= in_d;
      end
   end

endmodule

// File: rtl/he_pipe_enc.sv
// Streaming Hamming SEC encoder: scatter stage, then parity stage, full backpressure.
module he_pipe_enc
   import he_pkg::*;
#(
   parameter  int unsigned k  = 7,
   localparam int unsigned m  = he_m(k),
   localparam int unsigned CW = k + m
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [k-1:0]  din,
   input  logic          dvld,
   output logic          drdy,
   output logic [CW-1:0] cout,
   output logic          cvld,
   input  logic          crdy,
   output logic [15:0]   wcnt
);

   logic [CW-1:0]       s1_d_c;
   logic [CW-1:0]       s1_q;
   logic                s1_vld;
   logic                s1_rdy_c;
   logic                s2_rdy_c;
   logic [HE_M_MAX-1:0] par_c;
   logic [CW-1:0]       cw_c;

   assign s1_d_c = CW'(he_scatter(HE_K_MAX'(din), k));
   assign par_c  = he_parity(HE_CW_MAX'(s1_q), m);
   assign cw_c   = CW'(he_place(HE_CW_MAX'(s1_q), par_c, m));
   assign drdy   = rst && s1_rdy_c;

   he_pipe_stage #(.W(CW)) u_s1 (
      .clk      (clk),
      .rst      (rst),
      .in_d     (s1_d_c),
      .in_vld   (dvld),
      .in_rdy_c (s1_rdy_c),
      .out_d    (s1_q),
      .out_vld  (s1_vld),
      .out_rdy  (s2_rdy_c)
   );

   he_pipe_stage #(.W(CW)) u_s2 (
      .clk      (clk),
      .rst      (rst),
      .in_d     (cw_c),
      .in_vld   (s1_vld),
      .in_rdy_c (s2_rdy_c),
      .out_d    (cout),
      .out_vld  (cvld),
      .out_rdy  (crdy)
   );

   // Saturating count of codewords taken downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     wcnt <= '0;
      else if (cvld && crdy && wcnt != 16'hFFFF) wcnt <= wcnt + 16'd1;
   end

endmodule

// File: tb/tb_he_pipe_enc.sv
// Directed bench for he_pipe_enc (k=7): reset, known vectors, streaming, backpressure, reset, stalls.
module tb_he_pipe_enc;

   logic        clk;
   logic        rst;
   logic [6:0]  din;
   logic        dvld;
   logic        drdy;
   logic [10:0] cout;
   logic        cvld;
   logic        crdy;
   logic [15:0] wcnt;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          idx;
   int          got;
   int          sent;
   logic        pend;
   logic        stall_prev;
   logic [10:0] cout_prev;
   logic [10:0] flipped;
   logic [10:0] exp_cw;
   logic [10:0] expq[$];

   he_pipe_enc #(.k(7)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .dvld (dvld),
      .drdy (drdy),
      .cout (cout),
      .cvld (cvld),
      .crdy (crdy),
      .wcnt (wcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference encoder written out bit by bit for k=7.
   function automatic logic [10:0] enc7(input logic [6:0] d);
      logic p0, p1, p2, p3;
      p0 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      p1 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      p2 = d[1] ^ d[2] ^ d[3];
      p3 = d[4] ^ d[5] ^ d[6];
      return {d[6], d[5], d[4], p3, d[3], d[2], d[1], p2, d[0], p1, p0};
   endfunction

   // Syndrome decoder: corrects one flipped bit and extracts data.
   function automatic logic [6:0] dec7(input logic [10:0] c);
      logic [3:0]  s;
      logic [10:0] f;
      s = 4'd0;
      for (int j = 1; j <= 11; j++)
         if (c[4'(j - 1)]) s = s ^ 4'(j);
      f = c;
      if (s != 4'd0 && s <= 4'd11) f[s - 4'd1] = ~f[s - 4'd1];
      return {f[10], f[9], f[8], f[6], f[5], f[4], f[2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Send one word with crdy=1 and follow it through the two stages.
   task automatic send_known(input string tag, input logic [6:0] d, input logic [10:0] exp);
      din  = d;
      dvld = 1'b1;
      #1 chk({tag, "_drdy"}, 32'(drdy), 32'd1);
      cyc();
      dvld = 1'b0;
      #1 chk({tag, "_lat1"}, 32'(cvld), 32'd0);
      cyc();
      #1 chk({tag, "_cvld"}, 32'(cvld), 32'd1);
      chk({tag, "_cout"}, 32'(cout), 32'(exp));
      cyc();
      #1 chk({tag, "_gone"}, 32'(cvld), 32'd0);
   endtask

   initial begin
      rst  = 1'b0;
      dvld = 1'b1;
      din  = 7'h55;
      crdy = 1'b1;

      // Reset held with dvld asserted
      repeat (3) cyc();
      chk("rst_cvld", 32'(cvld), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_wcnt", 32'(wcnt), 32'd0);
      chk("rst_drdy", 32'(drdy), 32'd0);
      dvld = 1'b0;
      rst  = 1'b1;
      #1 chk("rel_drdy", 32'(drdy), 32'd1);
      cyc();

      send_known("k00", 7'h00, 11'h000);
      send_known("k01", 7'h01, 11'h007);
      send_known("k7f", 7'h7F, 11'h7FF);
      chk("known_wcnt", 32'(wcnt), 32'd3);

      // All 128 words back to back; single-bit flips must still decode
      idx = 0;
      for (int i = 0; i < 130; i++) begin
         if (i < 128) begin
            din  = 7'(i);
            dvld = 1'b1;
         end else dvld = 1'b0;
         #1;
         if (i < 128) chk("stream_drdy", 32'(drdy), 32'd1);
         if (i >= 2)  chk("stream_cvld", 32'(cvld), 32'd1);
         if (cvld) begin
            chk("stream_cout", 32'(cout), 32'(enc7(7'(idx))));
            chk("stream_dec", 32'(dec7(cout)), 32'(idx));
            flipped = cout ^ 11'(1 << (idx % 11));
            chk("stream_flip", 32'(dec7(flipped)), 32'(idx));
            idx++;
         end
         cyc();
      end
      chk("stream_count", 32'(idx), 32'd128);
      chk("stream_wcnt", 32'(wcnt), 32'd131);

      // Backpressure: s1 accepts behind a stalled s2, then fills
      crdy = 1'b0;
      din  = 7'h12;
      dvld = 1'b1;
      cyc();
      dvld = 1'b0;
      cyc();
      #1 chk("bp_s2only_drdy", 32'(drdy), 32'd1);
      din  = 7'h34;
      dvld = 1'b1;
      cyc();
      din = 7'h56;
      #1 chk("bp_full_drdy", 32'(drdy), 32'd0);
      chk("bp_full_cvld", 32'(cvld), 32'd1);
      chk("bp_full_cout", 32'(cout), 32'(enc7(7'h12)));
      cyc();
      #1 chk("bp_hold_cout", 32'(cout), 32'(enc7(7'h12)));
      chk("bp_hold_drdy", 32'(drdy), 32'd0);
      crdy = 1'b1;
      #1 chk("bp_release_drdy", 32'(drdy), 32'd1);
      cyc();
      crdy = 1'b0;
      dvld = 1'b0;
      #1 chk("bp_w1_cout", 32'(cout), 32'(enc7(7'h34)));
      chk("bp_w1_wcnt", 32'(wcnt), 32'd132);
      cyc();
      crdy = 1'b1;
      #1 chk("bp_w1_hold", 32'(cout), 32'(enc7(7'h34)));
      cyc();
      #1 chk("bp_w2_cout", 32'(cout), 32'(enc7(7'h56)));
      chk("bp_w2_cvld", 32'(cvld), 32'd1);
      cyc();
      #1 chk("bp_empty", 32'(cvld), 32'd0);
      chk("bp_wcnt", 32'(wcnt), 32'd134);

      // Mid-stream reset with two words in flight
      crdy = 1'b0;
      din  = 7'h11;
      dvld = 1'b1;
      cyc();
      din = 7'h22;
      cyc();
      dvld = 1'b0;
      #1 chk("mr_inflight", 32'(cvld), 32'd1);
      rst = 1'b0;
      #1 chk("mr_cvld_async", 32'(cvld), 32'd0);
      chk("mr_drdy", 32'(drdy), 32'd0);
      chk("mr_cout", 32'(cout), 32'd0);
      chk("mr_wcnt", 32'(wcnt), 32'd0);
      cyc();
      rst  = 1'b1;
      crdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("mr_no_ghost", 32'(cvld), 32'd0);
         cyc();
      end
      send_known("mr_new", 7'h2A, 11'h2D0);
      chk("mr_wcnt_restart", 32'(wcnt), 32'd1);

      // 1000 words with random dvld/crdy
      got        = 0;
      sent       = 0;
      pend       = 1'b0;
      stall_prev = 1'b0;
      cout_prev  = '0;
      for (int c = 0; c < 20000 && got < 1000; c++) begin
         if (!pend && sent < 1000 && $urandom_range(0, 2) != 0) begin
            pend = 1'b1;
            din  = 7'($urandom);
         end
         dvld = pend;
         crdy = ($urandom_range(0, 3) != 0);
         #1;
         if (stall_prev) begin
            chk("rand_stall_cout", 32'(cout), 32'(cout_prev));
            chk("rand_stall_cvld", 32'(cvld), 32'd1);
         end
         if (cvld && crdy) begin
            chk("rand_q_nonempty", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
               exp_cw = expq.pop_front();
               chk("rand_cout", 32'(cout), 32'(exp_cw));
            end
            got++;
         end
         if (dvld && drdy) begin
            expq.push_back(enc7(din));
            pend = 1'b0;
            sent++;
         end
         stall_prev = cvld && !crdy;
         cout_prev  = cout;
         cyc();
      end
      dvld = 1'b0;
      chk("rand_got", 32'(got), 32'd1000);
      chk("rand_left", 32'(expq.size()), 32'd0);
      chk("rand_wcnt", 32'(wcnt), 32'd1001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
